tdm_demux_1to4: RTL and testbench

//   Receive end of the 4-channel time-division link that the 4:1 mux drives.

---
 rtl/tdm_demux_1to4.sv | 136 +++++++++++++
 tb/tb_tdm_demux_1to4.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_1to4.sv
// tdm_demux_1to4 -- receive end of a 4-slot time-division link.
// Collects one WIDTH-bit beat per slot (slot 0 marked by in_sof) and
// publishes each complete frame to channel outputs a..d in a single edge.
// Frame alignment is tracked with a HUNT/LOCKED state machine; alignment
// violations raise a one-cycle err_sync pulse.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid            beat present this cycle (always accepted)
//   in_sof              start of frame, qualified by in_valid (slot 0)
//   in_data [WIDTH]     slot payload
//   a, b, c, d [WIDTH]  slots 0..3 of the last complete frame
//   out_valid           1-cycle pulse: a..d just updated
//   sel [2]             slot index expected for the next accepted beat
//   locked              frame alignment held
//   err_sync            1-cycle pulse: alignment violation detected
module tdm_demux_1to4 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             out_valid,
  output logic [1:0]       sel,
  output logic             locked,
  output logic             err_sync
);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t           state, state_n;
  logic [1:0]       sel_n;
  logic [WIDTH-1:0] s0, s1, s2;
  logic [WIDTH-1:0] s0_n, s1_n, s2_n;
  logic [WIDTH-1:0] a_n, b_n, c_n, d_n;
  logic             out_valid_n, err_sync_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      sel       <= '0;
      s0        <= '0;
      s1        <= '0;
      s2        <= '0;
      a         <= '0;
      b         <= '0;
      c         <= '0;
      d         <= '0;
      out_valid <= 1'b0;
      err_sync  <= 1'b0;
    end else begin
      state     <= state_n;
      sel       <= sel_n;
      s0        <= s0_n;
      s1        <= s1_n;
      s2        <= s2_n;
      a         <= a_n;
      b         <= b_n;
      c         <= c_n;
      d         <= d_n;
      out_valid <= out_valid_n;
      err_sync  <= err_sync_n;
    end
  end

  always_comb begin
    state_n     = state;
    sel_n       = sel;
    s0_n        = s0;
    s1_n        = s1;
    s2_n        = s2;
    a_n         = a;
    b_n         = b;
    c_n         = c;
    d_n         = d;
    out_valid_n = 1'b0;
    err_sync_n  = 1'b0;

    if (in_valid) begin
      case (state)
        HUNT: begin
          // Non-SOF beats while hunting are dropped silently.
          if (in_sof) begin
            s0_n    = in_data;
            sel_n   = 2'd1;
            state_n = LOCKED;
          end
        end
        LOCKED: begin
          if (sel == 2'd0) begin
            if (in_sof) begin
              s0_n  = in_data;
              sel_n = 2'd1;
            end else begin
              err_sync_n = 1'b1;
              sel_n      = 2'd0;
              state_n    = HUNT;
            end
          end else if (in_sof) begin
            // Early SOF: abandon the partial frame, restart at slot 0.
            err_sync_n = 1'b1;
            s0_n       = in_data;
            sel_n      = 2'd1;
          end else begin
            case (sel)
              2'd1:    s1_n = in_data;
              2'd2:    s2_n = in_data;
              default: begin
                // Slot 3 goes straight to d so all four outputs move together.
                a_n         = s0;
                b_n         = s1;
                c_n         = s2;
                d_n         = in_data;
                out_valid_n = 1'b1;
              end
            endcase
            sel_n = sel + 2'd1;
          end
        end
        default: begin
          state_n = HUNT;
          sel_n   = 2'd0;
        end
      endcase
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_tdm_demux_1to4.sv
module tb_tdm_demux_1to4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_sof;
  logic [7:0] in_data;
  logic [7:0] a, b, c, d;
  logic       out_valid, locked, err_sync;
  logic [1:0] sel;

  int checks   = 0;
  int failures = 0;

  tdm_demux_1to4 #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
    .in_data(in_data), .a(a), .b(b), .c(c), .d(d), .out_valid(out_valid),
    .sel(sel), .locked(locked), .err_sync(err_sync)
  );

  always #5 clk = ~clk;

  // Reference model: a frame is the list of slots collected since the last
  // SOF; its length is the slot expected next.
  bit         m_locked;
  logic [7:0] m_frame[$];
  logic [7:0] m_a, m_b, m_c, m_d;
  bit         m_ov, m_err;

  task automatic model_reset();
    m_locked = 0;
    m_frame.delete();
    m_a = 0; m_b = 0; m_c = 0; m_d = 0;
    m_ov = 0; m_err = 0;
  endtask

  task automatic model_step(input bit v, input bit sof, input logic [7:0] data);
    m_ov = 0;
    m_err = 0;
    if (!v) return;
    if (!m_locked) begin
      if (sof) begin
        m_frame.delete();
        m_frame.push_back(data);
        m_locked = 1;
      end
    end else if (m_frame.size() == 0) begin
      if (sof) m_frame.push_back(data);
      else begin
        m_err = 1;
        m_locked = 0;
      end
    end else if (sof) begin
      m_err = 1;
      m_frame.delete();
      m_frame.push_back(data);
    end else begin
      m_frame.push_back(data);
      if (m_frame.size() == 4) begin
        m_a = m_frame[0]; m_b = m_frame[1]; m_c = m_frame[2]; m_d = m_frame[3];
        m_ov = 1;
        m_frame.delete();
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("a", 32'(a), 32'(m_a));
    chk("b", 32'(b), 32'(m_b));
    chk("c", 32'(c), 32'(m_c));
    chk("d", 32'(d), 32'(m_d));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("err_sync", 32'(err_sync), 32'(m_err));
    chk("locked", 32'(locked), 32'(m_locked));
    chk("sel", 32'(sel), 32'(m_frame.size()));
  endtask

  // Drive one cycle of input, advance to the next falling edge, compare.
  task automatic tick(input bit v, input bit sof, input logic [7:0] data);
    in_valid = v;
    in_sof   = sof;
    in_data  = data;
    model_step(v, sof, data);
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    in_valid = 0; in_sof = 0; in_data = 0;
    rst_n = 0;
    #1;
    model_reset();
    chk("rst_a", 32'(a), 0);
    chk("rst_d", 32'(d), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_ov", 32'(out_valid), 0);
    chk("rst_err", 32'(err_sync), 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    compare();
  endtask

  task automatic frame(input logic [7:0] d0, d1, d2, d3);
    tick(1, 1, d0);
    tick(1, 0, d1);
    tick(1, 0, d2);
    tick(1, 0, d3);
  endtask

  int ov_count;

  initial begin
    rst_n = 1; in_valid = 0; in_sof = 0; in_data = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // 1. basic frame
    frame(8'h11, 8'h22, 8'h33, 8'h44);
    chk("t1_ov", 32'(out_valid), 1);
    chk("t1_abcd", {a, b, c, d}, 32'h11223344);
    chk("t1_locked", 32'(locked), 1);
    chk("t1_sel", 32'(sel), 0);

    // 2. same frame with 2 idle cycles between beats
    do_reset();
    ov_count = 0;
    for (int unsigned i = 0; i < 4; i++) begin
      tick(1, i == 0, 8'(8'h11 * (i + 1)));
      if (out_valid) ov_count++;
      for (int unsigned g = 0; g < 2; g++) begin
        tick(0, 0, 8'hEE);
        if (out_valid) ov_count++;
      end
    end
    chk("t2_ov_count", 32'(ov_count), 1);
    chk("t2_abcd", {a, b, c, d}, 32'h11223344);

    // 3. non-SOF beats while hunting
    do_reset();
    tick(1, 0, 8'hAA);
    chk("t3_err", 32'(err_sync), 0);
    tick(1, 0, 8'hBB);
    chk("t3_locked", 32'(locked), 0);
    chk("t3_abcd", {a, b, c, d}, 32'h0);

    // 4. early SOF drops the partial frame
    frame(8'hF1, 8'hF2, 8'hF3, 8'hF4);
    tick(1, 1, 8'h01);
    tick(1, 0, 8'h02);
    tick(1, 1, 8'h05);
    chk("t4_err", 32'(err_sync), 1);
    chk("t4_locked", 32'(locked), 1);
    tick(1, 0, 8'h06);
    chk("t4_err_clear", 32'(err_sync), 0);
    tick(1, 0, 8'h07);
    tick(1, 0, 8'h08);
    chk("t4_abcd", {a, b, c, d}, 32'h05060708);

    // 5. slot-0 beat without SOF
    tick(1, 0, 8'h99);
    chk("t5_err", 32'(err_sync), 1);
    chk("t5_locked", 32'(locked), 0);
    chk("t5_abcd", {a, b, c, d}, 32'h05060708);

    // 6. full-rate frames, reset mid frame 2
    frame(8'h31, 8'h32, 8'h33, 8'h34);
    tick(1, 1, 8'h41);
    tick(1, 0, 8'h42);
    do_reset();
    frame(8'h51, 8'h52, 8'h53, 8'h54);
    chk("t6_abcd", {a, b, c, d}, 32'h51525354);
    frame(8'h61, 8'h62, 8'h63, 8'h64);
    frame(8'h71, 8'h72, 8'h73, 8'h74);
    chk("t6_ov_b2b", 32'(out_valid), 1);

    // randomized traffic
    for (int unsigned i = 0; i < 3000; i++) begin
      bit v, s;
      v = ($urandom_range(0, 9) < 7);
      if (m_frame.size() == 0) s = ($urandom_range(0, 9) < 7);
      else                     s = ($urandom_range(0, 19) == 0);
      tick(v, s, 8'($urandom));
      if (out_valid && err_sync) begin
        checks++;
        failures++;
        $display("FAIL ov_err_exclusive: both high at %0t", $time);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
